// File: rtl/npc_mem_pkg.sv
// ============================================================
// npc_mem_pkg: shared types and widths for the data-memory arbiter
// Rev 1.0
// ============================================================
`default_nettype none

package npc_mem_pkg;
   localparam int MEM_AW  = 32;
   localparam int MEM_DW  = 32;
   localparam int WMASK_W = 8;

   localparam logic OWNER_IFU = 1'b0;
   localparam logic OWNER_LSU = 1'b1;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      RESP   = 2'd2
   } state_e;
endpackage

`default_nettype wire

// File: rtl/rr_arb2.sv
// ============================================================
// rr_arb2: two-input round-robin arbiter, history updated on accept
// Rev 1.0
// ============================================================
`default_nettype none

module rr_arb2 (
   input  logic       clk_i,
   input  logic       rst_i,
   input  logic [1:0] req_i,
   input  logic       accept_i,
   output logic [1:0] gnt_o
);
   // Reset history points at input 1 so input 0 wins the first tie.
   logic last_grant_q;
   logic last_grant_d;

   always_comb begin
      gnt_o = 2'b00;
      case (req_i)
         2'b01:   gnt_o = 2'b01;
         2'b10:   gnt_o = 2'b10;
         2'b11:   gnt_o = last_grant_q ? 2'b01 : 2'b10;
         default: gnt_o = 2'b00;
      endcase
      last_grant_d = accept_i ? gnt_o[1] : last_grant_q;
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) last_grant_q <= 1'b1;
      else       last_grant_q <= last_grant_d;
   end
endmodule

`default_nettype wire

// File: rtl/mem_arbiter.sv
// ============================================================
// mem_arbiter: IFU/LSU arbiter and fixed-latency memory sequencer
// Rev 1.0
// ============================================================
`default_nettype none

module mem_arbiter
   import npc_mem_pkg::*;
#(
   parameter int ACCESS_CYCLES = 1,
   parameter int AW            = MEM_AW,
   parameter int DW            = MEM_DW
) (
   input  logic               clock,
   input  logic               reset,
   input  logic               ifu_req_valid,
   output logic               ifu_req_ready,
   input  logic [AW-1:0]      ifu_addr,
   output logic               ifu_resp_valid,
   input  logic               ifu_resp_ready,
   output logic [DW-1:0]      ifu_rdata,
   input  logic               lsu_req_valid,
   output logic               lsu_req_ready,
   input  logic [AW-1:0]      lsu_addr,
   input  logic               lsu_wen,
   input  logic [DW-1:0]      lsu_wdata,
   input  logic [WMASK_W-1:0] lsu_wmask,
   output logic               lsu_resp_valid,
   input  logic               lsu_resp_ready,
   output logic [DW-1:0]      lsu_rdata,
   output logic               mem_valid,
   output logic [AW-1:0]      mem_raddr,
   output logic               mem_wen,
   output logic [AW-1:0]      mem_waddr,
   output logic [WMASK_W-1:0] mem_wmask,
   output logic [DW-1:0]      mem_wdata,
   input  logic [DW-1:0]      mem_rdata
);
   localparam int            CW       = (ACCESS_CYCLES > 1) ? $clog2(ACCESS_CYCLES) : 1;
   localparam logic [CW-1:0] CNT_INIT = CW'(ACCESS_CYCLES - 1);

   state_e               state_q;
   logic                 owner_q;
   logic [CW-1:0]        cnt_q;
   logic                 mem_valid_q, mem_wen_q;
   logic [AW-1:0]        mem_addr_q;
   logic [WMASK_W-1:0]   mem_wmask_q;
   logic [DW-1:0]        mem_wdata_q;
   logic                 ifu_resp_valid_q, lsu_resp_valid_q;
   logic [DW-1:0]        ifu_rdata_q, lsu_rdata_q;

   logic [1:0]           gnt;
   logic                 idle, accept;
   logic [AW-1:0]        addr_d;
   logic                 wen_d;
   logic [DW-1:0]        wdata_d;
   logic [WMASK_W-1:0]   wmask_d;

   rr_arb2 u_arb (
      .clk_i    (clock),
      .rst_i    (reset),
      .req_i    ({lsu_req_valid, ifu_req_valid}),
      .accept_i (accept),
      .gnt_o    (gnt)
   );

   // Ready is gated by reset so nothing is offered while the block is held off.
   assign idle          = (state_q == IDLE) && !reset;
   assign ifu_req_ready = idle && gnt[0];
   assign lsu_req_ready = idle && gnt[1];
   assign accept        = ifu_req_ready || lsu_req_ready;

   always_comb begin
      addr_d  = gnt[1] ? lsu_addr : ifu_addr;
      wen_d   = gnt[1] && lsu_wen;
      wdata_d = wen_d ? lsu_wdata : '0;
      wmask_d = wen_d ? lsu_wmask : '0;
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q          <= IDLE;
         owner_q          <= OWNER_IFU;
         cnt_q            <= '0;
         mem_valid_q      <= 1'b0;
         mem_wen_q        <= 1'b0;
         mem_addr_q       <= '0;
         mem_wmask_q      <= '0;
         mem_wdata_q      <= '0;
         ifu_resp_valid_q <= 1'b0;
         lsu_resp_valid_q <= 1'b0;
         ifu_rdata_q      <= '0;
         lsu_rdata_q      <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (accept) begin
                  owner_q     <= gnt[1] ? OWNER_LSU : OWNER_IFU;
                  cnt_q       <= CNT_INIT;
                  mem_valid_q <= 1'b1;
                  mem_wen_q   <= wen_d;
                  mem_addr_q  <= addr_d;
                  mem_wmask_q <= wmask_d;
                  mem_wdata_q <= wdata_d;
                  state_q     <= ACCESS;
               end
            end
            ACCESS: begin
               if (cnt_q == '0) begin
                  if (owner_q == OWNER_LSU) begin
                     lsu_rdata_q      <= mem_rdata;
                     lsu_resp_valid_q <= 1'b1;
                  end else begin
                     ifu_rdata_q      <= mem_rdata;
                     ifu_resp_valid_q <= 1'b1;
                  end
                  mem_valid_q <= 1'b0;
                  mem_wen_q   <= 1'b0;
                  mem_addr_q  <= '0;
                  mem_wmask_q <= '0;
                  mem_wdata_q <= '0;
                  state_q     <= RESP;
               end else begin
                  cnt_q <= cnt_q - 1'b1;
               end
            end
            RESP: begin
               if ((owner_q == OWNER_LSU && lsu_resp_ready) ||
                   (owner_q == OWNER_IFU && ifu_resp_ready)) begin
                  ifu_resp_valid_q <= 1'b0;
                  lsu_resp_valid_q <= 1'b0;
                  state_q          <= IDLE;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign mem_valid      = mem_valid_q;
   assign mem_wen        = mem_wen_q;
   assign mem_raddr      = mem_addr_q;
   assign mem_waddr      = mem_addr_q;
   assign mem_wmask      = mem_wmask_q;
   assign mem_wdata      = mem_wdata_q;
   assign ifu_resp_valid = ifu_resp_valid_q;
   assign lsu_resp_valid = lsu_resp_valid_q;
   assign ifu_rdata      = ifu_rdata_q;
   assign lsu_rdata      = lsu_rdata_q;
endmodule

`default_nettype wire

// File: tb/tb_mem_arbiter.sv
// ============================================================
// tb_mem_arbiter: transaction-level model check of mem_arbiter
// Rev 1.0
// ============================================================
`default_nettype none

module tb_mem_arbiter;
   import npc_mem_pkg::*;

   localparam int          AC      = 3;
   localparam logic [31:0] A_FETCH = 32'h8000_0000;
   localparam logic [31:0] A_DATA  = 32'h8000_1000;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   logic        ifu_req_valid = 1'b0, ifu_resp_ready = 1'b1;
   logic        lsu_req_valid = 1'b0, lsu_wen = 1'b0, lsu_resp_ready = 1'b1;
   logic [31:0] ifu_addr = '0, lsu_addr = '0, lsu_wdata = '0;
   logic [7:0]  lsu_wmask = '0;
   logic        ifu_req_ready, ifu_resp_valid, lsu_req_ready, lsu_resp_valid, mem_valid, mem_wen;
   logic [31:0] ifu_rdata, lsu_rdata, mem_raddr, mem_waddr, mem_wdata, mem_rdata;
   logic [7:0]  mem_wmask;

   logic [31:0] memarr [4096];
   assign mem_rdata = memarr[mem_raddr[13:2]];

   mem_arbiter #(.ACCESS_CYCLES(AC)) u_dut (
      .clock(clk), .reset(rst),
      .ifu_req_valid(ifu_req_valid), .ifu_req_ready(ifu_req_ready), .ifu_addr(ifu_addr),
      .ifu_resp_valid(ifu_resp_valid), .ifu_resp_ready(ifu_resp_ready), .ifu_rdata(ifu_rdata),
      .lsu_req_valid(lsu_req_valid), .lsu_req_ready(lsu_req_ready), .lsu_addr(lsu_addr),
      .lsu_wen(lsu_wen), .lsu_wdata(lsu_wdata), .lsu_wmask(lsu_wmask),
      .lsu_resp_valid(lsu_resp_valid), .lsu_resp_ready(lsu_resp_ready), .lsu_rdata(lsu_rdata),
      .mem_valid(mem_valid), .mem_raddr(mem_raddr), .mem_wen(mem_wen), .mem_waddr(mem_waddr),
      .mem_wmask(mem_wmask), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
   );

   // Two extra instances for latency at ACCESS_CYCLES = 1 and 4.
   logic [1:0]  l_req = 2'b00;
   logic [1:0]  l_rdy, l_rspv, l_lrdy, l_lrspv, l_mv, l_mwen;
   logic [31:0] l_irdata [2], l_lrdata [2], l_raddr [2], l_waddr [2], l_wdata [2];
   logic [7:0]  l_wmask [2];
   logic [31:0] lat_rdata = 32'h1234_5678;

   for (genvar g = 0; g < 2; g++) begin : g_lat
      mem_arbiter #(.ACCESS_CYCLES(g == 0 ? 1 : 4)) u_lat (
         .clock(clk), .reset(rst),
         .ifu_req_valid(l_req[g]), .ifu_req_ready(l_rdy[g]), .ifu_addr(A_FETCH),
         .ifu_resp_valid(l_rspv[g]), .ifu_resp_ready(1'b1), .ifu_rdata(l_irdata[g]),
         .lsu_req_valid(1'b0), .lsu_req_ready(l_lrdy[g]), .lsu_addr(32'h0),
         .lsu_wen(1'b0), .lsu_wdata(32'h0), .lsu_wmask(8'h0),
         .lsu_resp_valid(l_lrspv[g]), .lsu_resp_ready(1'b1), .lsu_rdata(l_lrdata[g]),
         .mem_valid(l_mv[g]), .mem_raddr(l_raddr[g]), .mem_wen(l_mwen[g]), .mem_waddr(l_waddr[g]),
         .mem_wmask(l_wmask[g]), .mem_wdata(l_wdata[g]), .mem_rdata(lat_rdata)
      );
   end

   int n_cmp = 0;
   int n_err = 0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   function automatic logic [11:0] idx(input logic [31:0] a);
      return a[13:2];
   endfunction

   // Model: one outstanding transaction, tracked by age in cycles since accept.
   bit          m_busy = 0;
   int          m_age = 0;
   logic        m_owner = 0, m_last = OWNER_LSU, m_wen = 0;
   logic [31:0] m_addr = 0, m_wdata = 0;
   logic [7:0]  m_wmask = 0;
   logic [31:0] m_rd [2] = '{32'h0, 32'h0};

   int   cyc = 0, hs_count = 0, hs_cyc = 0, rv_cyc = 0, resp_cnt = 0;
   int   writes = 0, wen_cycles = 0, mv_cycles = 0;
   bit   prev_rv = 0;
   int   hs_log [$];
   bit          pend = 0;
   logic [31:0] pend_addr = 0, pend_data = 0;
   logic [7:0]  pend_mask = 0;

   always @(negedge clk) begin : p_model
      logic ir, lr, acc, rsp;
      cyc++;
      if (ifu_resp_valid || lsu_resp_valid) resp_cnt++;
      if (rst) begin
         chk("rst_mem_valid", mem_valid, 0);
         chk("rst_mem_wen", mem_wen, 0);
         chk("rst_ifu_ready", ifu_req_ready, 0);
         chk("rst_lsu_ready", lsu_req_ready, 0);
         chk("rst_ifu_rv", ifu_resp_valid, 0);
         chk("rst_lsu_rv", lsu_resp_valid, 0);
         chk("rst_mem_addr", {mem_raddr, mem_waddr}, 0);
         chk("rst_mem_wd", {mem_wmask, mem_wdata}, 0);
         chk("rst_rdata", {ifu_rdata, lsu_rdata}, 0);
         m_busy = 0; m_last = OWNER_LSU; m_rd[0] = 0; m_rd[1] = 0;
         pend = 0; prev_rv = 0;
      end else begin
         acc = m_busy && m_age <= AC;
         rsp = m_busy && m_age > AC;
         ir  = !m_busy && ifu_req_valid && (!lsu_req_valid || m_last == OWNER_LSU);
         lr  = !m_busy && lsu_req_valid && !ir;
         chk("ifu_req_ready", ifu_req_ready, ir);
         chk("lsu_req_ready", lsu_req_ready, lr);
         chk("mem_valid", mem_valid, acc);
         chk("mem_raddr", mem_raddr, acc ? m_addr : 32'h0);
         chk("mem_waddr", mem_waddr, acc ? m_addr : 32'h0);
         chk("mem_wen", mem_wen, acc && m_wen);
         chk("mem_wmask", mem_wmask, (acc && m_wen) ? m_wmask : 8'h0);
         chk("mem_wdata", mem_wdata, (acc && m_wen) ? m_wdata : 32'h0);
         chk("ifu_resp_valid", ifu_resp_valid, rsp && m_owner == OWNER_IFU);
         chk("lsu_resp_valid", lsu_resp_valid, rsp && m_owner == OWNER_LSU);
         chk("ifu_rdata", ifu_rdata, m_rd[0]);
         chk("lsu_rdata", lsu_rdata, m_rd[1]);
         if (ifu_req_valid && ifu_req_ready) begin hs_log.push_back(0); hs_count++; end
         if (lsu_req_valid && lsu_req_ready) begin hs_log.push_back(1); hs_count++; end
         if ((ifu_resp_valid || lsu_resp_valid) && !prev_rv) rv_cyc = cyc;
         prev_rv = ifu_resp_valid || lsu_resp_valid;
         if (mem_wen) wen_cycles++;
         if (mem_valid) mv_cycles++;
         // Memory commits a store once the access window closes.
         if (mem_valid && mem_wen) begin
            pend = 1; pend_addr = mem_waddr; pend_data = mem_wdata; pend_mask = mem_wmask;
         end else if (!mem_valid && pend) begin
            for (int b = 0; b < 4; b++)
               if (pend_mask[b]) memarr[idx(pend_addr)][8*b +: 8] = pend_data[8*b +: 8];
            writes++; pend = 0;
         end
         if (!m_busy) begin
            if (ir || lr) begin
               m_busy = 1; m_age = 1; m_owner = lr; m_last = lr; hs_cyc = cyc;
               m_addr  = lr ? lsu_addr : ifu_addr;
               m_wen   = lr && lsu_wen;
               m_wdata = lsu_wdata; m_wmask = lsu_wmask;
            end
         end else if (m_age <= AC) begin
            if (m_age == AC) m_rd[m_owner] = memarr[idx(m_addr)];
            m_age++;
         end else if (m_owner == OWNER_LSU ? lsu_resp_ready : ifu_resp_ready) begin
            m_busy = 0;
         end
      end
   end

   task automatic tick();
      @(posedge clk); #1;
   endtask

   task automatic do_req(input bit lsu, input logic [31:0] a, input bit w,
                         input logic [31:0] d, input logic [7:0] m);
      int n0 = hs_count;
      if (lsu) begin
         lsu_req_valid = 1; lsu_addr = a; lsu_wen = w; lsu_wdata = d; lsu_wmask = m;
      end else begin
         ifu_req_valid = 1; ifu_addr = a;
      end
      for (int i = 0; i < 40 && hs_count == n0; i++) tick();
      chk("handshake", hs_count - n0, 1);
      ifu_req_valid = 0; lsu_req_valid = 0;
   endtask

   task automatic wait_idle();
      for (int i = 0; i < 60 && m_busy; i++) tick();
      chk("idle_timeout", m_busy, 0);
   endtask

   task automatic meas(input int k, output int lat);
      int t0 = -1;
      lat = -1;
      l_req[k] = 1;
      for (int i = 0; i < 60 && lat < 0; i++) begin
         @(negedge clk);
         if (t0 < 0 && l_rdy[k]) begin
            t0 = i;
            @(posedge clk); #1 l_req[k] = 0;
         end else if (t0 >= 0 && l_rspv[k]) begin
            lat = i - t0;
         end
      end
      l_req[k] = 0;
   endtask

   initial begin : p_stim
      int lat, n0, w0, wen0, mv0, rv0;
      for (int i = 0; i < 4096; i++) memarr[i] = 32'h0;
      memarr[idx(A_FETCH)] = 32'h0000_0413;

      // Reset with a pending IFU request: nothing may be offered.
      ifu_req_valid = 1;
      repeat (2) @(posedge clk);
      #2;
      chk("reset_ifu_ready", ifu_req_ready, 0);
      chk("reset_mem_valid", mem_valid, 0);
      ifu_req_valid = 0;
      rst = 0;
      tick();

      // IFU read alone.
      wen0 = wen_cycles;
      do_req(0, A_FETCH, 0, 0, 0);
      wait_idle();
      chk("ifu_latency", rv_cyc - hs_cyc, AC + 1);
      chk("ifu_fetch_data", ifu_rdata, 32'h0000_0413);
      chk("ifu_no_wen", wen_cycles - wen0, 0);

      // LSU store then load.
      w0 = writes; mv0 = mv_cycles;
      do_req(1, A_DATA, 1, 32'hDEAD_BEEF, 8'h0F);
      wait_idle();
      tick();
      chk("store_writes", writes - w0, 1);
      chk("store_valid_cycles", mv_cycles - mv0, AC);
      chk("store_mem", memarr[idx(A_DATA)], 32'hDEAD_BEEF);
      chk("store_prewrite_rdata", lsu_rdata, 32'h0);
      do_req(1, A_DATA, 0, 0, 0);
      wait_idle();
      chk("load_data", lsu_rdata, 32'hDEAD_BEEF);

      // Reset during ACCESS.
      do_req(0, A_FETCH, 0, 0, 0);
      #1 rst = 1;
      #1;
      chk("async_mem_valid", mem_valid, 0);
      chk("async_mem_raddr", mem_raddr, 0);
      chk("async_ifu_rv", ifu_resp_valid, 0);
      @(negedge clk);
      @(posedge clk); #2 rst = 0;
      rv0 = resp_cnt;
      repeat (6) tick();
      chk("reset_no_resp", resp_cnt - rv0, 0);

      // Both requesters from reset: alternation IFU, LSU, IFU, LSU.
      hs_log.delete();
      ifu_addr = A_FETCH; lsu_addr = A_DATA; lsu_wen = 0;
      ifu_req_valid = 1; lsu_req_valid = 1;
      for (int i = 0; i < 80 && hs_log.size() < 3; i++) tick();
      ifu_req_valid = 0;
      for (int i = 0; i < 40 && hs_log.size() < 4; i++) tick();
      lsu_req_valid = 0;
      wait_idle();
      chk("alt_count", hs_log.size(), 4);
      if (hs_log.size() == 4) begin
         chk("alt_0", hs_log[0], 0);
         chk("alt_1", hs_log[1], 1);
         chk("alt_2", hs_log[2], 0);
         chk("alt_3", hs_log[3], 1);
      end

      // LSU response backpressure with IFU waiting.
      lsu_resp_ready = 0;
      do_req(1, A_DATA, 0, 0, 0);
      ifu_req_valid = 1; ifu_addr = A_FETCH;
      for (int i = 0; i < 20 && !lsu_resp_valid; i++) tick();
      chk("bp_resp_seen", lsu_resp_valid, 1);
      repeat (5) begin
         tick();
         chk("bp_resp_valid", lsu_resp_valid, 1);
         chk("bp_rdata", lsu_rdata, 32'hDEAD_BEEF);
         chk("bp_ifu_ready", ifu_req_ready, 0);
      end
      lsu_resp_ready = 1;
      n0 = hs_count;
      for (int i = 0; i < 20 && hs_count == n0; i++) tick();
      chk("bp_ifu_served", hs_count - n0, 1);
      ifu_req_valid = 0;
      wait_idle();
      chk("bp_ifu_data", ifu_rdata, 32'h0000_0413);

      // Latency at the two other access times.
      meas(0, lat);
      chk("latency_ac1", lat, 2);
      chk("lat1_rdata", l_irdata[0], 32'h1234_5678);
      meas(1, lat);
      chk("latency_ac4", lat, 5);
      chk("lat4_rdata", l_irdata[1], 32'h1234_5678);

      repeat (2) tick();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin : p_watchdog
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end
endmodule

`default_nettype wire
